// File: rtl/div_pkg.sv
// Shared constants, state encoding and operand helper for the multi-cycle divider.
package div_pkg;

  localparam int unsigned RegBus = 32;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic RstEnable         = 1'b1;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Number of restoring iterations, one quotient bit each.
  localparam logic [5:0] DivIters = 6'd32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Magnitude of an operand; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [RegBus-1:0] op_mag(input logic [RegBus-1:0] x,
                                               input logic is_signed);
    return (is_signed && x[RegBus-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32/32 restoring divider; result_o = {remainder, quotient}.
module div
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [RegBus-1:0]   opdata1_i,
  input  logic [RegBus-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*RegBus-1:0] result_o,
  output logic                ready_o
);

  div_state_e          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*RegBus:0]   work_q, work_d;
  logic [RegBus-1:0]   divisor_q, divisor_d;
  logic                signed_q, signed_d;
  logic                op1_msb_q, op1_msb_d;
  logic                op2_msb_q, op2_msb_d;
  logic [2*RegBus-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [RegBus:0]     diff;
  logic                neg_quo;
  logic                neg_rem;
  logic                accept;

  assign diff    = {1'b0, work_q[2*RegBus-1:RegBus]} - {1'b0, divisor_q};
  // Sign fix uses operand signs captured at start, not the live inputs.
  assign neg_quo = signed_q & (op1_msb_q ^ op2_msb_q);
  assign neg_rem = signed_q & op1_msb_q;
  assign accept  = (start_i == DivStart) && !annul_i;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      op1_msb_q <= 1'b0;
      op2_msb_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      op1_msb_q <= op1_msb_d;
      op2_msb_q <= op2_msb_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (accept) state_d = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      end
      DivByZero: state_d = DivEnd;
      DivOn: begin
        if (annul_i)                state_d = DivFree;
        else if (cnt_q == DivIters) state_d = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    op1_msb_d = op1_msb_q;
    op2_msb_d = op2_msb_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
        if (accept) begin
          signed_d  = signed_div_i;
          op1_msb_d = opdata1_i[RegBus-1];
          op2_msb_d = opdata2_i[RegBus-1];
          if (opdata2_i != ZeroWord) begin
            cnt_d     = '0;
            work_d    = {ZeroWord, op_mag(opdata1_i, signed_div_i), 1'b0};
            divisor_d = op_mag(opdata2_i, signed_div_i);
          end
        end
      end
      DivByZero: work_d = '0;
      DivOn: begin
        if (annul_i) begin
          cnt_d = '0;
        end else if (cnt_q < DivIters) begin
          if (diff[RegBus]) begin
            work_d = {work_q[2*RegBus-1:0], 1'b0};
          end else begin
            work_d = {diff[RegBus-1:0], work_q[RegBus-1:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          if (neg_quo) work_d[RegBus-1:0] = ~work_q[RegBus-1:0] + 1'b1;
          if (neg_rem) work_d[2*RegBus:RegBus+1] = ~work_q[2*RegBus:RegBus+1] + 1'b1;
          cnt_d = '0;
        end
      end
      DivEnd: begin
        if (start_i == DivStart) begin
          result_d = {work_q[2*RegBus:RegBus+1], work_q[RegBus-1:0]};
          ready_d  = DivResultReady;
        end else begin
          result_d = {ZeroWord, ZeroWord};
          ready_d  = DivResultNotReady;
        end
      end
      default: ;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed, table-driven bench for the multi-cycle divider.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp  = 0;
  int n_fail = 0;

  div u_dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Starts one division, scrambles inputs while it runs, checks latency, result,
  // hold behaviour in DivEnd (with annul asserted) and the return to idle.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int id);
    int k;
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    @(posedge clk); #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    if (b == 32'd0) annul_i = 1'b1;
    k = 0;
    while (!ready_o && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    lat = ready_o ? k : -1;
    chk($sformatf("v%0d latency", id), 64'(lat), 64'(exp_lat));
    chk($sformatf("v%0d result", id), result_o, exp);
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d hold ready", id), {63'd0, ready_o}, 64'd1);
    chk($sformatf("v%0d hold result", id), result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d stop ready", id), {63'd0, ready_o}, 64'd0);
    chk($sformatf("v%0d stop result", id), result_o, 64'd0);
  endtask

  vec_t vecs[14];
  int   seen;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF,   32'hFFFFFFFD}};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,          32'h80000000}};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'h1,          {32'h0,          32'hFFFFFFFF}};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'd0};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD}};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF,   32'd3}};
    vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'h2,          {32'd1,          32'h7FFFFFFC}};
    vecs[8]  = '{1'b0, 32'd0,          32'd5,          64'd0};
    vecs[9]  = '{1'b0, 32'd9,          32'd3,          {32'd0,          32'd3}};
    vecs[10] = '{1'b1, 32'h80000000,   32'd2,          {32'd0,          32'hC0000000}};
    vecs[11] = '{1'b0, 32'h80000000,   32'd2,          {32'd0,          32'h40000000}};
    vecs[12] = '{1'b0, 32'd3,          32'd10,         {32'd3,          32'd0}};
    vecs[13] = '{1'b1, 32'hFFFFFFFF,   32'd0,          64'd0};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, i);
    end

    // Annul at edge N+10, then stay idle through N+40.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("annul idle", 64'(seen), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 100);

    // Reset at edge N+20 mid-operation.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst mid ready", {63'd0, ready_o}, 64'd0);
    chk("rst mid result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("rst idle", 64'(seen), 64'd0);
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 101);

    // Reset while holding a finished result.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (35) @(posedge clk);
    #1;
    chk("end ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst end ready", {63'd0, ready_o}, 64'd0);
    chk("rst end result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
